bcd_adder: RTL and testbench
============================

// Module: bcd_adder
// PURPOSE
//  Single-digit BCD adder: adds two 4-bit BCD digits X, Y plus carry-in c_in.
//  Produces a packed two-digit BCD result, a decimal carry-out and an
//  out-of-range flag.
//  Building block for multi-digit BCD arithmetic: c_out chains to the next digit's c_in.
//  Outputs are registered, so the block sits on the one design clock.
// PARAMETERS
//  none (fixed 4-bit digit inputs, 8-bit packed BCD result)
// PORTS
//  clk           input   1  design clock; all state updates on posedge
//  rst           input   1  reset, asynchronous, active-high
//  X             input   4  BCD addend digit, valid 0..9
//  Y             input   4  BCD addend digit, valid 0..9
//  c_in          input   1  decimal carry-in (0 or 1)
//  c_out         output  1  decimal carry-out: 1 when X+Y+c_in >= 10
//  result        output  8  packed BCD sum {tens[7:4], ones[3:0]}
//  out_of_range  output  1  1 when X > 9 or Y > 9
// BEHAVIOUR
//  - Reset: while rst=1 (asynchronously on assertion), c_out=0, result=8'h00
//    and out_of_range=0. The first capture happens on the first posedge
//    after rst deasserts. Asserting rst mid-stream discards the pending
//    result immediately.
//  - Latency: inputs are sampled on posedge clk. The outputs for those
//    inputs are valid after that same edge (1-cycle latency).
//  - Throughput: one new operand set is accepted every cycle. No handshake;
//    outputs hold until the next edge.
//  - Arithmetic, for X,Y <= 9: S = X + Y + c_in, computed 5 bits wide
//    (range 0..19).
//    - S <= 9:  result = {4'h0, S[3:0]},    c_out = 0
//    - S >= 10: result = {4'h1, S-10 [3:0]}, c_out = 1
//      (equivalent to adding 6 to the binary sum)
//    - result[7:4] is always 0 or 1 and always equals c_out.
//  - Out-of-range (X > 9 or Y > 9, X/Y in 10..15): out_of_range=1,
//    result=8'h00, c_out=0. c_in is ignored in this case.
//  - out_of_range is registered with the same 1-cycle latency as result.
//  - c_in is treated strictly as 0/1. X=Y=9 with c_in=1 gives the maximum
//    legal result, 8'h19.
//  - Outputs never carry X/Z after reset. All 512 combinations of
//    {c_in, X, Y} give defined outputs.
// TESTING
//  - Reset: assert rst with X=5,Y=5,c_in=1 -> outputs 0/8'h00/0 at once,
//    and they stay there while rst=1.
//  - No carry: X=3,Y=4,c_in=0 -> next edge: result=8'h07, c_out=0,
//    out_of_range=0.
//  - Decimal carry: X=9,Y=9,c_in=1 -> result=8'h19, c_out=1.
//    X=5,Y=5,c_in=0 -> result=8'h10, c_out=1.
//  - Boundary: X=9,Y=0,c_in=1 -> result=8'h10, c_out=1.
//    X=9,Y=0,c_in=0 -> result=8'h09, c_out=0.
//  - Out of range: X=10,Y=2,c_in=0 and X=3,Y=15,c_in=1 -> out_of_range=1,
//    result=8'h00, c_out=0.
//  - Exhaustive sweep: all 512 {c_in,X,Y}, one per clock -> each output
//    matches the reference model 1 cycle later; back-to-back changes
//    never drop a value.

Source files
------------

// File: rtl/bcd_adder_if.sv
// bcd_adder_if: operand and result bundle for one BCD digit slice.
interface bcd_adder_if;
  logic [3:0] X;
  logic [3:0] Y;
  logic       c_in;
  logic       c_out;
  logic [7:0] result;
  logic       out_of_range;
  modport master (output X, Y, c_in, input c_out, result, out_of_range);
  modport slave  (input X, Y, c_in, output c_out, result, out_of_range);
endinterface

// File: rtl/bcd_adder.sv
// bcd_adder: registered single-digit BCD adder with decimal carry and range flag.
module bcd_adder (
  input logic        clk,
  input logic        rst,
  bcd_adder_if.slave bus
);
  logic [4:0] sum;
  logic       bad, carry;
  logic [7:0] result_d, result_q;
  logic       c_out_d, c_out_q, oor_d, oor_q;
  always_comb begin
    sum      = {1'b0, bus.X} + {1'b0, bus.Y} + {4'b0, bus.c_in};
    bad      = (bus.X > 4'd9) || (bus.Y > 4'd9);
    carry    = sum >= 5'd10;
    // Out-of-range operands force a clean zero result so downstream digits see no carry.
    result_d = bad ? 8'h00 : carry ? {4'h1, sum[3:0] + 4'd6} : {4'h0, sum[3:0]};
    c_out_d  = !bad && carry;
    oor_d    = bad;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 8'h00;
      c_out_q  <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      c_out_q  <= c_out_d;
      oor_q    <= oor_d;
    end
  end
  assign bus.result       = result_q;
  assign bus.c_out        = c_out_q;
  assign bus.out_of_range = oor_q;
endmodule

// File: tb/tb_bcd_adder.sv
// tb_bcd_adder: directed vectors plus an exhaustive sweep against a decimal model.
module tb_bcd_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bcd_adder_if bus ();
  bcd_adder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [9:0] obs();
    return {bus.out_of_range, bus.c_out, bus.result};
  endfunction
  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {oor,cout,res}=%h want %h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] model(input int c, input int x, input int y);
    int s, tens, ones;
    if (x > 9 || y > 9) return 10'h200;
    s    = x + y + c;
    tens = s / 10;
    ones = s % 10;
    return {1'b0, tens[0], tens[3:0], ones[3:0]};
  endfunction
  task automatic apply(input string tag, input int c, input int x, input int y, input logic [9:0] exp);
    @(negedge clk);
    bus.X    = x[3:0];
    bus.Y    = y[3:0];
    bus.c_in = c[0];
    @(posedge clk);
    #1 chk(tag, obs(), exp);
  endtask
  initial begin
    bus.X    = 4'd5;
    bus.Y    = 4'd5;
    bus.c_in = 1'b1;
    #2 rst = 1'b1;
    #1 chk("rst_async", obs(), 10'h000);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", obs(), 10'h000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("first_capture", obs(), 10'h111);
    apply("no_carry_3_4_0", 0, 3, 4, 10'h007);
    apply("max_9_9_1", 1, 9, 9, 10'h119);
    apply("carry_5_5_0", 0, 5, 5, 10'h110);
    apply("bound_9_0_1", 1, 9, 0, 10'h110);
    apply("bound_9_0_0", 0, 9, 0, 10'h009);
    apply("oor_10_2_0", 0, 10, 2, 10'h200);
    apply("oor_3_15_1", 1, 3, 15, 10'h200);
    apply("after_oor_9_9_1", 1, 9, 9, 10'h119);
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_midstream", obs(), 10'h000);
    @(posedge clk);
    #1 chk("rst_mid_hold", obs(), 10'h000);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 512; i++) begin
      int c, x, y;
      c = i / 256;
      x = (i / 16) % 16;
      y = i % 16;
      apply($sformatf("sweep_c%0d_x%0d_y%0d", c, x, y), c, x, y, model(c, x, y));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
